// File: rtl/fixed_point_multiplier_seq_if.sv
// Start/busy/done handshake and operand/result bus for fixed_point_multiplier_seq.
// Operands and result are Q(WIDTH.FRACTIONAL_BITS), N = WIDTH + FRACTIONAL_BITS bits wide.
interface fixed_point_multiplier_seq_if #(
    parameter int WIDTH           = 8,
    parameter int FRACTIONAL_BITS = 8
);
    localparam int N = WIDTH + FRACTIONAL_BITS;

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Result;
    logic         overflow;

    modport master (
        output start, A, B,
        input  busy, done, Result, overflow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Result, overflow
    );
endinterface

// File: rtl/fixed_point_multiplier_seq.sv
// Sequential unsigned Q(WIDTH.FRACTIONAL_BITS) shift-and-add multiplier, one bit per clock.
// Optional build macro FIXED_MUL_SATURATE_EN: saturate Result to all ones on overflow.
module fixed_point_multiplier_seq #(
    parameter int WIDTH           = 8,
    parameter int FRACTIONAL_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    fixed_point_multiplier_seq_if.slave  bus
);
    localparam int N  = WIDTH + FRACTIONAL_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] next_acc;
    logic [N-1:0]   result;
    logic           ovf;
    logic           done;
    logic           last;
    logic [N-1:0]   res_next;
    logic           ovf_next;

    // Partial product for this bit; the final edge uses it directly as the full product.
    always_comb begin
        next_acc = acc + (mplier[0] ? mcand : '0);
        last     = (cnt == CW'(N - 1));
        ovf_next = |next_acc[2*N-1 : FRACTIONAL_BITS+N];
`ifdef FIXED_MUL_SATURATE_EN
        res_next = ovf_next ? '1 : next_acc[FRACTIONAL_BITS+N-1 : FRACTIONAL_BITS];
`else
        res_next = next_acc[FRACTIONAL_BITS+N-1 : FRACTIONAL_BITS];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            result <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    mcand  <= {{N{1'b0}}, bus.A};
                    mplier <= bus.B;
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= RUN;
                end
            end else begin
                acc    <= next_acc;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    result <= res_next;
                    ovf    <= ovf_next;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = done;
    assign bus.Result   = result;
    assign bus.overflow = ovf;
endmodule
